// File: rtl/line_arbiter_pkg.sv
// Shared types and constants for the cache-line arbiter.
package line_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        RESP
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

    localparam int LINE_BEATS  = 4;
    localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/line_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory signals around the arbiter.
// The arbiter takes the slave view; caches and memory take the master view.
interface line_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);

    logic                  i_line_read;
    logic [ADDR_WIDTH-1:0] i_line_address;
    logic [LINE_WIDTH-1:0] i_line_rdata;
    logic                  i_line_resp;

    logic                  d_line_read;
    logic                  d_line_write;
    logic [ADDR_WIDTH-1:0] d_line_address;
    logic [LINE_WIDTH-1:0] d_line_wdata;
    logic [LINE_WIDTH-1:0] d_line_rdata;
    logic                  d_line_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [BEAT_WIDTH-1:0] pmem_wdata;
    logic [BEAT_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_line_read, i_line_address,
        output i_line_rdata, i_line_resp,
        input  d_line_read, d_line_write, d_line_address, d_line_wdata,
        output d_line_rdata, d_line_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_line_read, i_line_address,
        input  i_line_rdata, i_line_resp,
        output d_line_read, d_line_write, d_line_address, d_line_wdata,
        input  d_line_rdata, d_line_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/line_arbiter_assembler.sv
// Beat-indexed view of a cache line: extracts the current beat for writes
// and merges an incoming beat into the line for reads.
module line_arbiter_assembler #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int BEAT_BITS  = 2
) (
    input  logic [LINE_WIDTH-1:0] line_in,
    input  logic [BEAT_BITS-1:0]  beat,
    input  logic [BEAT_WIDTH-1:0] beat_in,
    output logic [BEAT_WIDTH-1:0] beat_out,
    output logic [LINE_WIDTH-1:0] line_out
);

    // Slice the selected beat out, and produce the line with that beat replaced
    always_comb begin
        beat_out = line_in[int'(beat) * BEAT_WIDTH +: BEAT_WIDTH];
        line_out = line_in;
        line_out[int'(beat) * BEAT_WIDTH +: BEAT_WIDTH] = beat_in;
    end

endmodule

// File: rtl/line_arbiter.sv
// Round-robin arbiter moving 256-bit I-cache fills and D-cache fills or
// writebacks over a single 64-bit physical memory port as 4-beat bursts.
module line_arbiter
    import line_arbiter_pkg::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    line_arbiter_if.slave  bus
);

    localparam int BEATS     = LINE_WIDTH / BEAT_WIDTH;
    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    arb_state_t            state;
    arb_src_t              src;
    arb_src_t              last_grant;
    arb_src_t              grant_src;
    logic [BEAT_BITS-1:0]  beat;
    logic [LINE_WIDTH-1:0] line_buf;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_q;
    logic                  wr_q;
    logic [LINE_WIDTH-1:0] i_rdata_q;
    logic [LINE_WIDTH-1:0] d_rdata_q;
    logic                  i_resp_q;
    logic                  d_resp_q;

    logic                  i_req;
    logic                  d_req;
    logic [BEAT_WIDTH-1:0] beat_slice;
    logic [LINE_WIDTH-1:0] line_merged;
    logic                  unused_addr_bits;

    assign i_req = bus.i_line_read;
    assign d_req = bus.d_line_read | bus.d_line_write;

    // Offset bits are forced to zero on the memory side and never needed here
    assign unused_addr_bits = ^{bus.i_line_address[OFFSET_BITS-1:0],
                                bus.d_line_address[OFFSET_BITS-1:0]};

    line_arbiter_assembler #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEAT_BITS  (BEAT_BITS)
    ) u_assembler (
        .line_in  (line_buf),
        .beat     (beat),
        .beat_in  (bus.pmem_rdata),
        .beat_out (beat_slice),
        .line_out (line_merged)
    );

    // Pick a requester: the lone one, or the one not served last when both wait
    always_comb begin
        grant_src = SRC_I;
        if (i_req && d_req) begin
            grant_src = (last_grant == SRC_I) ? SRC_D : SRC_I;
        end else if (d_req) begin
            grant_src = SRC_D;
        end
    end

    // Arbitration, burst sequencing and completion FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            src        <= SRC_I;
            last_grant <= SRC_I;
            beat       <= '0;
            line_buf   <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_resp_q   <= 1'b0;
            d_resp_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        src        <= grant_src;
                        last_grant <= grant_src;
                        beat       <= '0;
                        state      <= BURST;
                        if (grant_src == SRC_D) begin
                            addr_q   <= {bus.d_line_address[ADDR_WIDTH-1:OFFSET_BITS],
                                         {OFFSET_BITS{1'b0}}};
                            rd_q     <= ~bus.d_line_write;
                            wr_q     <= bus.d_line_write;
                            line_buf <= bus.d_line_wdata;
                        end else begin
                            addr_q   <= {bus.i_line_address[ADDR_WIDTH-1:OFFSET_BITS],
                                         {OFFSET_BITS{1'b0}}};
                            rd_q     <= 1'b1;
                            wr_q     <= 1'b0;
                        end
                    end
                end
                BURST: begin
                    if (bus.pmem_resp) begin
                        beat <= beat + 1'b1;
                        if (!wr_q) begin
                            line_buf <= line_merged;
                        end
                        if (beat == LAST_BEAT) begin
                            rd_q  <= 1'b0;
                            wr_q  <= 1'b0;
                            state <= RESP;
                            if (src == SRC_I) begin
                                i_resp_q  <= 1'b1;
                                i_rdata_q <= line_merged;
                            end else begin
                                d_resp_q <= 1'b1;
                                if (!wr_q) begin
                                    d_rdata_q <= line_merged;
                                end
                            end
                        end
                    end
                end
                RESP: begin
                    i_resp_q <= 1'b0;
                    d_resp_q <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wr_q ? beat_slice : '0;
    assign bus.i_line_rdata = i_rdata_q;
    assign bus.i_line_resp  = i_resp_q;
    assign bus.d_line_rdata = d_rdata_q;
    assign bus.d_line_resp  = d_resp_q;

endmodule

// File: tb/tb_line_arbiter.sv
// Self-checking bench for line_arbiter: table of single transactions plus
// hand-written contention, reset-abort and spurious-response sequences.
module tb_line_arbiter;

    import line_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    line_arbiter_if #(.LINE_WIDTH(256), .BEAT_WIDTH(64), .ADDR_WIDTH(32)) bus ();

    line_arbiter #(.LINE_WIDTH(256), .BEAT_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit           is_d;
        bit           is_write;
        logic [31:0]  addr;
        logic [255:0] line;
    } txn_t;

    typedef struct {
        bit           is_d;
        bit           is_write;
        logic [31:0]  addr;
        logic [255:0] line;
        int           gap;
        logic [31:0]  exp_addr;
    } vec_t;

    txn_t expQ[$];
    vec_t vecs[4];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] mkLine(input logic [7:0] tag);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < LINE_BEATS; k++) begin
            l[k*64 +: 64] = {8{tag + 8'(k)}};
        end
        return l;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_pmem_read", bus.pmem_read, 0);
        checkOutput("rst_pmem_write", bus.pmem_write, 0);
        checkOutput("rst_pmem_address", bus.pmem_address, 0);
        checkOutput("rst_pmem_wdata", bus.pmem_wdata, 0);
        checkOutput("rst_i_line_rdata", bus.i_line_rdata, 0);
        checkOutput("rst_d_line_rdata", bus.d_line_rdata, 0);
        checkOutput("rst_i_line_resp", bus.i_line_resp, 0);
        checkOutput("rst_d_line_resp", bus.d_line_resp, 0);
    endtask

    // Raise one request and record the transaction it should produce
    task automatic applyStimulus(input bit is_d, input bit is_write,
                                 input logic [31:0] addr, input logic [255:0] line,
                                 input logic [31:0] exp_addr);
        txn_t t;
        t.is_d     = is_d;
        t.is_write = is_write;
        t.addr     = exp_addr;
        t.line     = line;
        expQ.push_back(t);
        if (is_d) begin
            bus.d_line_read    = ~is_write;
            bus.d_line_write   = is_write;
            bus.d_line_address = addr;
            bus.d_line_wdata   = is_write ? line : ~line;
        end else begin
            bus.i_line_read    = 1'b1;
            bus.i_line_address = addr;
        end
    endtask

    // Act as memory for one burst, checking it against the oldest expectation
    task automatic serviceBurst(input int gap, input bit respDuringResp, output int waited);
        txn_t       exp;
        int         cnt;
        logic [1:0] expOp;
        cnt = 0;
        while (!(bus.pmem_read || bus.pmem_write) && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        waited = cnt;
        if (cnt >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL burst_start: got no burst expected burst within 50 cycles");
            return;
        end
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got unexpected burst expected none");
            return;
        end
        exp   = expQ.pop_front();
        expOp = exp.is_write ? 2'b01 : 2'b10;
        checkOutput("pmem_address", bus.pmem_address, exp.addr);
        checkOutput("pmem_op", {bus.pmem_read, bus.pmem_write}, expOp);
        if (exp.is_d) begin
            bus.d_line_address = ~exp.addr;
            bus.d_line_wdata   = ~exp.line;
        end else begin
            bus.i_line_address = ~exp.addr;
        end
        for (int b = 0; b < LINE_BEATS; b++) begin
            for (int g = 0; g < gap; g++) begin
                bus.pmem_resp  = 1'b0;
                bus.pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                @(negedge clk);
                checkOutput("stall_address", bus.pmem_address, exp.addr);
                checkOutput("stall_op", {bus.pmem_read, bus.pmem_write}, expOp);
                if (exp.is_write) begin
                    checkOutput("stall_wdata", bus.pmem_wdata, exp.line[b*64 +: 64]);
                end
            end
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = exp.is_write ? 64'hDEAD_BEEF_DEAD_BEEF : exp.line[b*64 +: 64];
            if (exp.is_write) begin
                checkOutput("pmem_wdata", bus.pmem_wdata, exp.line[b*64 +: 64]);
            end
            @(negedge clk);
        end
        bus.pmem_resp = respDuringResp;
        checkOutput("op_drop", {bus.pmem_read, bus.pmem_write}, 2'b00);
        checkOutput("i_line_resp", bus.i_line_resp, !exp.is_d);
        checkOutput("d_line_resp", bus.d_line_resp, exp.is_d);
        if (!exp.is_write) begin
            if (exp.is_d) checkOutput("d_line_rdata", bus.d_line_rdata, exp.line);
            else          checkOutput("i_line_rdata", bus.i_line_rdata, exp.line);
        end
        if (exp.is_d) begin
            bus.d_line_read  = 1'b0;
            bus.d_line_write = 1'b0;
        end else begin
            bus.i_line_read = 1'b0;
        end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        checkOutput("resp_pulse_end", {bus.i_line_resp, bus.d_line_resp}, 2'b00);
    endtask

    task automatic clearInputs();
        bus.i_line_read    = 1'b0;
        bus.i_line_address = '0;
        bus.d_line_read    = 1'b0;
        bus.d_line_write   = 1'b0;
        bus.d_line_address = '0;
        bus.d_line_wdata   = '0;
        bus.pmem_rdata     = '0;
        bus.pmem_resp      = 1'b0;
    endtask

    task automatic applyReset();
        clearInputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Main test sequence
    initial begin
        int          waited;
        logic [31:0] ia;
        logic [31:0] da;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clearInputs();
        #2;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkResetOutputs();
        rst = 1'b1;
        @(negedge clk);

        vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, mkLine(8'hA0), 0, 32'h0000_1220};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0047,
                    {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 32'h8000_0040};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_ABCD, mkLine(8'h5C), 3, 32'h0000_ABC0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, mkLine(8'hE7), 1, 32'hFFFF_FFE0};

        $display("[TB] single-requester vectors");
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].is_d, vecs[v].is_write, vecs[v].addr,
                          vecs[v].line, vecs[v].exp_addr);
            @(negedge clk);
            serviceBurst(vecs[v].gap, 1'b0, waited);
            checkOutput("grant_latency", waited, 0);
        end

        $display("[TB] contention from reset");
        applyReset();
        for (int r = 0; r < 4; r++) begin
            ia = 32'h0001_0007 + 32'(r * 256);
            da = 32'h0002_001B + 32'(r * 256);
            applyStimulus(1'b1, r[0], da, mkLine(8'h20 + 8'(r * 16)), da & ~32'h1F);
            applyStimulus(1'b0, 1'b0, ia, mkLine(8'h80 + 8'(r * 16)), ia & ~32'h1F);
            @(negedge clk);
            serviceBurst(0, 1'b0, waited);
            serviceBurst(0, 1'b0, waited);
        end

        $display("[TB] contention after a D grant");
        applyStimulus(1'b1, 1'b0, 32'h0003_0000, mkLine(8'h31), 32'h0003_0000);
        @(negedge clk);
        serviceBurst(0, 1'b0, waited);
        applyStimulus(1'b0, 1'b0, 32'h0004_0040, mkLine(8'h41), 32'h0004_0040);
        applyStimulus(1'b1, 1'b1, 32'h0005_0060, mkLine(8'h51), 32'h0005_0060);
        @(negedge clk);
        serviceBurst(0, 1'b0, waited);
        serviceBurst(1, 1'b0, waited);

        $display("[TB] reset mid-burst");
        bus.i_line_read    = 1'b1;
        bus.i_line_address = 32'h0000_3040;
        @(negedge clk);
        checkOutput("abort_burst_on", bus.pmem_read, 1);
        for (int b = 0; b < 2; b++) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = 64'h7777_0000_0000_0000 + 64'(b);
            @(negedge clk);
        end
        bus.pmem_resp   = 1'b0;
        bus.i_line_read = 1'b0;
        rst = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clk);
        checkResetOutputs();
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0000_3040, mkLine(8'h60), 32'h0000_3040);
        @(negedge clk);
        serviceBurst(0, 1'b1, waited);
        checkOutput("post_abort_latency", waited, 0);

        $display("[TB] spurious pmem_resp in IDLE");
        for (int c = 0; c < 3; c++) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
            @(negedge clk);
            checkOutput("idle_spurious_op", {bus.pmem_read, bus.pmem_write}, 2'b00);
            checkOutput("idle_spurious_resp", {bus.i_line_resp, bus.d_line_resp}, 2'b00);
        end
        bus.pmem_resp = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_7F9F, mkLine(8'hC3), 32'h0000_7F80);
        @(negedge clk);
        serviceBurst(2, 1'b0, waited);
        checkOutput("post_spurious_latency", waited, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
